// File: rtl/tx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tx_mem_arbiter
// Grants one of two byte-stream requesters access to a TX frame buffer,
// writes the granted frame from address 0 upward, reports completion and
// then waits for the transmitter to drain the buffer before the next grant.
//
// Ports
//   i_clk, i_reset              : clock (rising edge), async active-high reset
//   i_reqN_valid/_data/_last    : requester N byte stream (N = 0, 1)
//   o_reqN_ready                : requester N byte accepted when valid&&ready
//   i_tx_done                   : transmitter has drained the buffer (pulse)
//   o_mem_en, o_mem_wen         : buffer write strobe (both high on a write)
//   o_mem_waddr, o_mem_wdata    : buffer write address / data
//   o_mem_wdone                 : one-cycle pulse, frame complete in buffer
//   o_mem_byte                  : byte count of the last completed frame
//   o_owner                     : requester currently / last granted
//   o_err_ovf, o_err_tmo        : sticky overflow / mid-frame timeout flags
// ---------------------------------------------------------------------------
module tx_mem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int MAX_BYTES   = 1023,
    parameter int TIMEOUT_CYC = 1250000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0_valid,
    input  logic [7:0]        i_req0_data,
    input  logic              i_req0_last,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [7:0]        i_req1_data,
    input  logic              i_req1_last,
    output logic              o_req1_ready,
    input  logic              i_tx_done,
    output logic              o_mem_en,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_wdone,
    output logic [ADDR_W-1:0] o_mem_byte,
    output logic              o_owner,
    output logic              o_err_ovf,
    output logic              o_err_tmo
);

    localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_ZERO  = ADDR_W'(0);
    // Count value before the byte that fills the frame to MAX_BYTES.
    localparam logic [ADDR_W-1:0] CNT_LIMIT = ADDR_W'(MAX_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ZERO  = TMO_W'(0);
    // Counter value during the last permitted idle cycle.
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2,
        WAIT_TX = 2'd3
    } state_t;

    state_t            state_r;
    logic              owner_r;
    logic [ADDR_W-1:0] count_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              ready0_r;
    logic              ready1_r;
    logic              mem_en_r;
    logic [ADDR_W-1:0] mem_waddr_r;
    logic [7:0]        mem_wdata_r;
    logic              mem_wdone_r;
    logic [ADDR_W-1:0] mem_byte_r;
    logic              err_ovf_r;
    logic              err_tmo_r;

    logic              accept_s;
    logic [7:0]        byte_s;
    logic              last_s;
    logic              grant_s;

    // Select the owner's stream; only the owner's ready can ever be high.
    always_comb begin
        accept_s = 1'b0;
        byte_s   = 8'h00;
        last_s   = 1'b0;
        if (owner_r == 1'b0) begin
            accept_s = i_req0_valid & ready0_r;
            byte_s   = i_req0_data;
            last_s   = i_req0_last;
        end else begin
            accept_s = i_req1_valid & ready1_r;
            byte_s   = i_req1_data;
            last_s   = i_req1_last;
        end
    end

    // Round-robin pick: under contention the previous owner yields.
    always_comb begin
        grant_s = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_s = ~owner_r;
        end else begin
            grant_s = i_req1_valid;
        end
    end

    // Arbitration / frame-write state machine with registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= IDLE;
            owner_r     <= 1'b1;
            count_r     <= CNT_ZERO;
            tmo_cnt_r   <= TMO_ZERO;
            ready0_r    <= 1'b0;
            ready1_r    <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_waddr_r <= CNT_ZERO;
            mem_wdata_r <= 8'h00;
            mem_wdone_r <= 1'b0;
            mem_byte_r  <= CNT_ZERO;
            err_ovf_r   <= 1'b0;
            err_tmo_r   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            mem_en_r    <= 1'b0;
            mem_wdone_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_req0_valid || i_req1_valid) begin
                        owner_r   <= grant_s;
                        count_r   <= CNT_ZERO;
                        tmo_cnt_r <= TMO_ZERO;
                        ready0_r  <= ~grant_s;
                        ready1_r  <= grant_s;
                        state_r   <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept_s) begin
                        mem_en_r    <= 1'b1;
                        mem_waddr_r <= count_r;
                        mem_wdata_r <= byte_s;
                        count_r     <= count_r + CNT_ONE;
                        tmo_cnt_r   <= TMO_ZERO;
                        if (last_s || (count_r == CNT_LIMIT)) begin
                            ready0_r <= 1'b0;
                            ready1_r <= 1'b0;
                            state_r  <= DONE;
                            if (!last_s) begin
                                err_ovf_r <= 1'b1;
                            end
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Stalled owner: flush what we have, or drop an empty frame.
                        err_tmo_r <= 1'b1;
                        ready0_r  <= 1'b0;
                        ready1_r  <= 1'b0;
                        state_r   <= (count_r != CNT_ZERO) ? DONE : IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                DONE: begin
                    mem_wdone_r <= 1'b1;
                    mem_byte_r  <= count_r;
                    state_r     <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    ready0_r <= 1'b0;
                    ready1_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign o_req0_ready = ready0_r;
    assign o_req1_ready = ready1_r;
    assign o_mem_en     = mem_en_r;
    assign o_mem_wen    = mem_en_r;
    assign o_mem_waddr  = mem_waddr_r;
    assign o_mem_wdata  = mem_wdata_r;
    assign o_mem_wdone  = mem_wdone_r;
    assign o_mem_byte   = mem_byte_r;
    assign o_owner      = owner_r;
    assign o_err_ovf    = err_ovf_r;
    assign o_err_tmo    = err_tmo_r;

endmodule

// File: tb/tb_tx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_mem_arbiter
// Directed and randomized frames against tx_mem_arbiter. Expected buffer
// contents, counts, owner and flags come from the bytes the bench itself
// handed over and from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_tx_mem_arbiter;

    localparam int ADDR_W    = 10;
    localparam int MAX_BYTES = 1023;
    localparam int TMO       = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_last, req1_valid, req1_last;
    logic [7:0]        req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              tx_done;
    logic              mem_en, mem_wen, mem_wdone, owner, err_ovf, err_tmo;
    logic [ADDR_W-1:0] mem_waddr, mem_byte;
    logic [7:0]        mem_wdata;

    tx_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req0_valid(req0_valid), .i_req0_data(req0_data), .i_req0_last(req0_last),
        .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_data(req1_data), .i_req1_last(req1_last),
        .o_req1_ready(req1_ready),
        .i_tx_done(tx_done),
        .o_mem_en(mem_en), .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr),
        .o_mem_wdata(mem_wdata), .o_mem_wdone(mem_wdone), .o_mem_byte(mem_byte),
        .o_owner(owner), .o_err_ovf(err_ovf), .o_err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t       wq[$];
    logic [7:0] sent0[$];
    logic [7:0] sent1[$];
    int        n_assert = 0;
    int        n_fail = 0;
    int        cyc = 0;
    int        wdone_cnt = 0;
    int        wdone_cyc = 0;
    int        last_wr_cyc = 0;
    int        viol = 0;
    int        model_owner = 1;
    int        ovf_exp = 0;
    int        tmo_exp = 0;

    // Observe buffer writes, wdone pulses and ready exclusivity just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_en) begin
            wq.push_back({mem_waddr, mem_wdata});
            last_wr_cyc = cyc;
            if (!mem_wen) viol++;
        end
        if (mem_wdone) begin
            wdone_cnt++;
            wdone_cyc = cyc;
        end
        if ((req0_ready && owner) || (req1_ready && !owner) || (req0_ready && req1_ready)) viol++;
    end

    // Watchdog so the run always terminates.
    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    function automatic logic rdy(input int r);
        return (r != 0) ? req1_ready : req0_ready;
    endfunction

    function automatic logic [7:0] sent_at(input int r, input int i);
        return (r != 0) ? sent1[i] : sent0[i];
    endfunction

    function automatic int sent_size(input int r);
        return (r != 0) ? sent1.size() : sent0.size();
    endfunction

    task automatic clear_mon();
        wq.delete();
        sent0.delete();
        sent1.delete();
        wdone_cnt = 0;
        viol = 0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk) tx_done = 1'b1;
        @(negedge clk) tx_done = 1'b0;
    endtask

    // Present n bytes (data base+i, or random when base<0); each byte waits at
    // most 'budget' cycles for ready. acc returns how many were accepted.
    task automatic send_frame(input int r, input int n, input bit use_last, input int max_gap,
                              input int budget, input int base, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            int         g;
            int         w;
            logic [7:0] d;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            d = (base >= 0) ? 8'(base + i) : 8'($urandom);
            w = 0;
            repeat (g) begin
                @(negedge clk);
                set_req(r, 1'b0, 8'h00, 1'b0);
            end
            @(negedge clk);
            set_req(r, 1'b1, d, use_last && (i == n - 1));
            while (!rdy(r) && w < budget) begin
                @(negedge clk);
                w++;
            end
            if (!rdy(r)) break;
            if (r != 0) sent1.push_back(d); else sent0.push_back(d);
            acc++;
        end
        @(negedge clk);
        set_req(r, 1'b0, 8'h00, 1'b0);
    endtask

    // Compare the captured writes and status against what requester r handed over.
    task automatic check_frame(input int r, input int k, input int exp_wd, input int exp_lat);
        int lim;
        check("n_writes", wq.size(), k);
        lim = (wq.size() < k) ? wq.size() : k;
        if (sent_size(r) < lim) lim = sent_size(r);
        for (int i = 0; i < lim; i++) begin
            check("waddr", wq[i].a, i);
            check("wdata", wq[i].d, sent_at(r, i));
        end
        check("wdone_cnt", wdone_cnt, exp_wd);
        if (exp_wd != 0) begin
            check("mem_byte", mem_byte, k);
            check("wdone_latency", wdone_cyc - last_wr_cyc, exp_lat);
        end
        check("owner", owner, r);
        check("err_ovf", err_ovf, ovf_exp);
        check("err_tmo", err_tmo, tmo_exp);
        check("ready_excl", viol, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {mem_en, mem_wen, mem_wdone, req0_ready, req1_ready, err_ovf, err_tmo}, 0);
        check({tag, "_waddr"}, mem_waddr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_byte"}, mem_byte, 0);
        check({tag, "_owner"}, owner, 1);
    endtask

    task automatic run_single(input int r, input int n, input int gap, input int base);
        int acc;
        clear_mon();
        send_frame(r, n, 1'b1, gap, 50, base, acc);
        model_owner = r;
        repeat (4) @(negedge clk);
        check("accepted", acc, n);
        // The other requester asks while the buffer is still full: no grant.
        set_req(1 - r, 1'b1, 8'h5a, 1'b0);
        repeat (3) @(negedge clk);
        check("wait_tx_ready", {req0_ready, req1_ready}, 0);
        set_req(1 - r, 1'b0, 8'h00, 1'b0);
        check_frame(r, n, 1, 1);
        pulse_tx_done();
    endtask

    task automatic run_both(input int n_first, input int n_second);
        int first;
        int second;
        int acc_f;
        int acc_s;
        first  = 1 - model_owner;
        second = model_owner;
        clear_mon();
        fork
            begin
                send_frame(second, n_second, 1'b1, 0, 300, -1, acc_s);
            end
            begin
                send_frame(first, n_first, 1'b1, 0, 300, -1, acc_f);
                repeat (4) @(negedge clk);
                check("acc_first", acc_f, n_first);
                check("loser_ready", rdy(second), 0);
                check_frame(first, n_first, 1, 1);
                clear_mon();
                pulse_tx_done();
            end
        join
        repeat (4) @(negedge clk);
        check("acc_second", acc_s, n_second);
        check_frame(second, n_second, 1, 1);
        pulse_tx_done();
        model_owner = second;
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        tx_done = 1'b0;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three fixed bytes from requester 0.
        run_single(0, 3, 0, 8'h41);

        // Contention right after a frame by 0: 1 wins, then 0.
        run_both(2 + int'($urandom_range(0, 6)), 2 + int'($urandom_range(0, 6)));

        // Randomized frames: single requesters with gaps, or contention.
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 2) == 0)
                run_both(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
            else
                run_single(int'($urandom_range(0, 1)), int'($urandom_range(1, 16)), 3, -1);
        end

        // i_tx_done in IDLE and mid-frame is ignored.
        clear_mon();
        pulse_tx_done();
        pulse_tx_done();
        check("idle_txdone_writes", wq.size(), 0);
        fork
            send_frame(1, 8, 1'b1, 0, 50, -1, acc);
            begin
                repeat (4) @(negedge clk);
                pulse_tx_done();
            end
        join
        repeat (4) @(negedge clk);
        check("write_txdone_acc", acc, 8);
        check_frame(1, 8, 1, 1);
        pulse_tx_done();
        model_owner = 1;

        // Overflow: 1100 bytes without last; frame closes at MAX_BYTES.
        clear_mon();
        send_frame(1, 1100, 1'b0, 0, 40, -1, acc);
        ovf_exp = 1;
        check("ovf_acc", acc, MAX_BYTES);
        check_frame(1, MAX_BYTES, 1, 1);
        pulse_tx_done();

        // Timeout after two bytes: flushed frame, wdone TMO+1 cycles after the last write.
        clear_mon();
        send_frame(0, 2, 1'b0, 0, 40, -1, acc);
        repeat (22) @(negedge clk);
        tmo_exp = 1;
        check("tmo_acc", acc, 2);
        check_frame(0, 2, 1, TMO + 1);
        pulse_tx_done();
        model_owner = 0;

        // Timeout with no byte accepted: back to IDLE, no wdone, no tx_done needed.
        clear_mon();
        @(negedge clk) set_req(0, 1'b1, 8'h99, 1'b0);
        @(negedge clk) set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (20) @(negedge clk);
        check("tmo0_writes", wq.size(), 0);
        check("tmo0_wdone", wdone_cnt, 0);
        check("tmo0_owner", owner, 0);
        check("tmo0_flag", err_tmo, 1);
        run_single(1, 4, 1, -1);

        // Reset mid-frame abandons the frame; flags clear; next frame starts at 0.
        clear_mon();
        send_frame(0, 5, 1'b0, 0, 40, -1, acc);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        check("midreset_writes", wq.size(), 5);
        @(negedge clk) rst = 1'b0;
        ovf_exp = 0;
        tmo_exp = 0;
        model_owner = 1;
        repeat (5) @(negedge clk);
        check("midreset_wdone", wdone_cnt, 0);
        run_single(0, 1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_mem_arbiter.md
TX_MEM_ARBITER -- requirements
Module: tx_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning TX buffer address width.
REQ-002 SHALL have parameter MAX_BYTES, default 1023, meaning maximum frame length in bytes; legal range 1..2^ADDR_W-1.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1250000, meaning idle cycles allowed mid-frame (10 ms at 125 MHz).
REQ-004 SHALL have i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have i_reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have i_req0_valid / i_req1_valid  input  1 each  requester byte valid.
REQ-007 SHALL have i_req0_data / i_req1_data  input  8 each  requester byte.
REQ-008 SHALL have i_req0_last / i_req1_last  input  1 each  byte is last of frame.
REQ-009 SHALL have o_req0_ready / o_req1_ready  output  1 each  byte accepted when valid&&ready.
REQ-010 SHALL have i_tx_done  input  1  one-cycle pulse from transmitter: buffer drained.
REQ-011 SHALL have o_mem_en, o_mem_wen  output  1 each  buffer write-port enable and write enable.
REQ-012 SHALL have o_mem_waddr  output  ADDR_W  buffer write address.
REQ-013 SHALL have o_mem_wdata  output  8  buffer write data.
REQ-014 SHALL have o_mem_wdone  output  1  one-cycle pulse: frame complete in buffer.
REQ-015 SHALL have o_mem_byte  output  ADDR_W  byte count of last completed frame.
REQ-016 SHALL have o_owner  output  1  requester currently or last granted.
REQ-017 SHALL have o_err_ovf, o_err_tmo  output  1 each  sticky overflow / timeout flags.

Function
REQ-018 SHALL implement states IDLE, WRITE, DONE, WAIT_TX.
REQ-019 IDLE: SHALL grant when any valid; single request -> that requester; both -> the one not equal to o_owner (round-robin); grant loads o_owner, clears count, -> WRITE next cycle.
REQ-020 o_reqN_ready SHALL be 1 only in WRITE with o_owner==N; the non-owner SHALL see ready 0 for the whole frame.
REQ-021 Accepted byte in cycle T SHALL produce o_mem_en=o_mem_wen=1, o_mem_waddr=count, o_mem_wdata=byte in T+1; count increments by 1; first byte of every frame at address 0.
REQ-022 Byte with last=1, or byte making count==MAX_BYTES, SHALL end the frame: WRITE -> DONE; the MAX_BYTES case without last SHALL set o_err_ovf.
REQ-023 DONE SHALL last one cycle, pulse o_mem_wdone for exactly one cycle in T+2 (T = final accept cycle), latch o_mem_byte=count, -> WAIT_TX.
REQ-024 WAIT_TX SHALL hold all ready low until i_tx_done, then -> IDLE; i_tx_done in any other state SHALL be ignored.
REQ-025 In WRITE, TIMEOUT_CYC consecutive cycles without an accepted byte SHALL set o_err_tmo; count>0 -> DONE (frame flushed with count bytes); count==0 -> IDLE, no wdone.
REQ-026 Timeout counter SHALL clear on every accepted byte and on entry to WRITE.
REQ-027 Frame ownership SHALL be held until frame end; owner valid deasserting mid-frame SHALL not release the grant before timeout.
REQ-028 o_mem_en/o_mem_wen SHALL be 0 in every cycle not following an accepted byte; no write SHALL occur outside a frame.
REQ-029 Error flags SHALL stay set until reset; they SHALL not block operation.

Reset
REQ-030 i_reset high SHALL immediately force state IDLE, count 0, timeout counter 0, all outputs 0, o_owner=1 (so requester 0 wins the first contention).
REQ-031 Reset mid-frame SHALL abandon the frame with no wdone; first post-reset frame SHALL start at address 0.

Verification
REQ-032 Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> writes addr 0,1,2 with those data, one wdone pulse, o_mem_byte=3, o_owner=0.
REQ-033 Both valid in IDLE after reset -> req0 granted; after i_tx_done both still valid -> req1 granted; req1 ready stays 0 throughout req0 frame.
REQ-034 Req1 streams 1100 bytes, no last -> wdone after byte 1023, o_mem_byte=1023, o_err_ovf=1, last write addr 1022, req1 ready 0 until i_tx_done.
REQ-035 TIMEOUT_CYC=16; req0 sends 2 bytes then drops valid -> o_err_tmo=1 after 16 idle cycles, wdone, o_mem_byte=2.
REQ-036 Assert i_reset after 5 bytes of a frame -> no wdone, all outputs 0; new 1-byte frame writes addr 0, o_mem_byte=1.
REQ-037 Pulse i_tx_done while in IDLE and WRITE -> no state change; frame completes normally.
